mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation MIPS core. Replaces the bare PC register plus combinational instruction-memory read.
- Owns the fetch PC and issues word requests to an instruction memory that may insert wait states.
- Buffers fetched words in a prefetch FIFO and hands them to decode through a valid/ready interface.
- Accepts branch, jump and jr redirects from execute, flushing the FIFO, and raises a fault on misaligned targets.

Parameters:
ADDR_W, 32, width of PC and instruction addresses in bits (>=IMEM_AW).
IMEM_AW, 9, byte-address bits driven to instruction memory.
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2.
RESET_PC, 0, fetch PC after reset; must be word aligned.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  synchronous active-low reset.
imem_req  output  1  fetch request, level.
imem_addr  output  IMEM_AW  byte address of requested word, fetch_pc[IMEM_AW-1:0].
imem_ack  input  1  memory accepts (req,addr) this cycle; imem_rdata valid.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
redirect  input  1  taken branch/jump/jr from execute.
redirect_pc  input  ADDR_W  redirect target.
inst_valid  output  1  FIFO head valid.
inst_ready  input  1  decode consumes head this cycle.
inst  output  32  head instruction; 0 when inst_valid=0.
inst_pc  output  ADDR_W  head instruction address; 0 when inst_valid=0.
inst_pc4  output  ADDR_W  inst_pc+4 (modulo 2^ADDR_W), for jal link; 0 when inst_valid=0.
fault  output  1  misaligned redirect seen; fetch stopped.
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=BOOT, fetch_pc=RESET_PC, FIFO empty.
  - All outputs 0: imem_req, inst_valid, inst, inst_pc, inst_pc4, fault, fifo_count.
  - Reset wins over every other input, including mid-transfer.
- FSM states:
  - BOOT: imem_req=0. Next state RUN unconditionally; a redirect in BOOT is ignored.
  - RUN: imem_req=1 iff fifo_count<FIFO_DEPTH, else go to HOLD. HOLD->RUN when fifo_count<FIFO_DEPTH.
  - HOLD: imem_req=0.
  - FAULT: imem_req=0, fault=1, FIFO empty. Leave FAULT only on an aligned redirect, which goes to RUN.
- Memory handshake:
  - A transfer completes on an edge where imem_req=1 and imem_ack=1.
  - On completion, {imem_rdata, fetch_pc} is pushed and fetch_pc+=4, wrapping modulo 2^ADDR_W.
  - imem_addr stays stable while imem_req=1 and no redirect occurs.
  - The memory keeps no state between cycles, so a request is abandoned if the address changes; at most one transfer per cycle.
- Latency:
  - Ack to inst_valid: 1 cycle. There is no bypass.
  - Redirect to first imem_req at the new address: next cycle.
  - Redirect to first inst_valid: at least 2 cycles.
- Decode handshake:
  - Pop on an edge with inst_valid=1 and inst_ready=1.
  - Head outputs are stable while inst_valid=1 and inst_ready=0.
- Push and pop on the same edge: fifo_count unchanged, order preserved. Push can never target a full FIFO because imem_req=0 when full.
- Aligned redirect (redirect=1, redirect_pc[1:0]=0):
  - Flush FIFO (count=0); fetch_pc=redirect_pc; state=RUN.
  - A same-cycle ack is discarded; a same-cycle pop is irrelevant.
- Misaligned redirect (redirect_pc[1:0]!=0): flush FIFO, fetch_pc unchanged, state=FAULT, fault=1 from next cycle.
- Redirect in HOLD: same as in RUN.
- Pointer wrap: FIFO read/write pointers wrap at FIFO_DEPTH; full/empty are derived from fifo_count.

Test Plan:
- Reset, then imem_ack tied 1, inst_ready tied 1 -> imem_req rises at cycle 2. inst_pc sequence 0x0,0x4,0x8,... one per cycle; inst_pc4 = inst_pc+4.
- inst_ready=0, ack always 1, FIFO_DEPTH=4 -> fifo_count reaches 4, imem_req drops, state HOLD. Then inst_ready=1 for one cycle -> count 3, one more fetch at 0x10, head 0x0 consumed.
- Ack every third cycle -> imem_addr held stable during waits; no duplicate or missing PCs over 20 instructions.
- Redirect to 0x40 on the same cycle as an ack of 0x8 -> 0x8 discarded, FIFO flushed, next imem_addr=0x40, first inst_pc after flush=0x40.
- Redirect to 0x42 -> fault=1 next cycle, imem_req=0, inst_valid=0. Then redirect to 0x80 -> fault=0, fetch resumes at 0x80.
- rst_n=0 for one cycle with 3 entries queued and a transfer pending -> all outputs 0, count 0, refetch from RESET_PC.
- ADDR_W=32 with redirect to 0xFFFFFFFC -> next fetch PC 0x0; inst_pc4 of that entry =0x0.

Source files
------------

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: memory, redirect and decode signals of the fetch front end.
// master is the fetch unit side; slave is the memory/execute/decode side.
interface mips_fetch_unit_if #(
    parameter int ADDR_W     = 32,
    parameter int IMEM_AW    = 9,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst;
    logic [ADDR_W-1:0]  inst_pc;
    logic [ADDR_W-1:0]  inst_pc4;
    logic               fault;
    logic [CW-1:0]      fifo_count;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4, fault, fifo_count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4, fault, fifo_count,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: fetch PC, wait-state tolerant imem requests, prefetch FIFO to decode.
// Redirects flush the FIFO; misaligned targets park the unit in FAULT until an aligned redirect.
module mips_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_AW    = 9,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input logic              clk,
    input logic              rst_n,
    mips_fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, FAULT} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              req, full, valid, aligned, flush, push, pop;

    assign full    = count == FULL;
    assign valid   = count != '0;
    assign aligned = bus.redirect_pc[1:0] == 2'b00;
    assign flush   = bus.redirect && state != BOOT;
    // A same-cycle ack is dropped on redirect: its word belongs to the abandoned stream.
    assign push    = req && bus.imem_ack && !flush;
    assign pop     = valid && bus.inst_ready && !flush;

    always_comb begin
        state_d = state;
        req     = 1'b0;
        case (state)
            BOOT: state_d = RUN;
            RUN, HOLD: begin
                req     = state == RUN && !full;
                state_d = flush ? (aligned ? RUN : FAULT) : (full ? HOLD : RUN);
            end
            default: state_d = flush && aligned ? RUN : FAULT;
        endcase
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetch_pc[IMEM_AW-1:0];
    assign bus.inst_valid = valid;
    assign bus.inst       = valid ? data_mem[rd_ptr] : '0;
    assign bus.inst_pc    = valid ? pc_mem[rd_ptr] : '0;
    assign bus.inst_pc4   = valid ? pc_mem[rd_ptr] + ADDR_W'(4) : '0;
    assign bus.fault      = state == FAULT;
    assign bus.fifo_count = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                if (aligned) fetch_pc <= bus.redirect_pc;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop) count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed checks of the fetch unit; memory returns 0xC0000000 | byte address.
module tb_mips_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mips_fetch_unit_if #(.ADDR_W(32), .IMEM_AW(9), .FIFO_DEPTH(4)) bus ();

    assign bus.imem_rdata = 32'hC000_0000 | {23'b0, bus.imem_addr};

    mips_fetch_unit #(.ADDR_W(32), .IMEM_AW(9), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req"}, bus.imem_req, 0);
        chk({tag, ".valid"}, bus.inst_valid, 0);
        chk({tag, ".inst"}, bus.inst, 0);
        chk({tag, ".pc"}, bus.inst_pc, 0);
        chk({tag, ".pc4"}, bus.inst_pc4, 0);
        chk({tag, ".fault"}, bus.fault, 0);
        chk({tag, ".count"}, bus.fifo_count, 0);
    endtask

    int          exp_pc;
    int          rcv;
    logic [8:0]  prev_addr;
    logic        prev_pending;

    initial begin
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        // streaming with ack and ready tied high
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        bus.imem_ack = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        chk("stream.req_rise", bus.imem_req, 1);
        chk("stream.addr0", bus.imem_addr, 0);
        chk("stream.no_bypass", bus.inst_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stream.pc", bus.inst_pc, 4 * i);
            chk("stream.pc4", bus.inst_pc4, 4 * i + 4);
            chk("stream.inst", bus.inst, 32'hC000_0000 | (4 * i));
            chk("stream.count", bus.fifo_count, 1);
        end

        // fill to full, hold, single pop, refill
        bus.inst_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("fill.count", bus.fifo_count, 4);
        chk("fill.req_drop", bus.imem_req, 0);
        tick();
        chk("hold.count", bus.fifo_count, 4);
        chk("hold.req", bus.imem_req, 0);
        chk("hold.head", bus.inst_pc, 0);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("pop1.count", bus.fifo_count, 3);
        chk("pop1.head", bus.inst_pc, 4);
        tick();
        chk("refill.req", bus.imem_req, 1);
        chk("refill.addr", bus.imem_addr, 9'h10);
        tick();
        chk("refill.count", bus.fifo_count, 4);
        bus.imem_ack = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("drain.head", bus.inst_pc, 4 * i);
        end
        tick();
        chk("drain.valid", bus.inst_valid, 0);
        chk("drain.count", bus.fifo_count, 0);
        chk("drain.pc_zero", bus.inst_pc, 0);

        // ack every third cycle
        do_reset();
        exp_pc = 0;
        rcv = 0;
        for (int c = 0; c < 90 && rcv < 20; c++) begin
            bus.imem_ack = (c % 3 == 2);
            prev_addr = bus.imem_addr;
            prev_pending = bus.imem_req && !bus.imem_ack;
            tick();
            if (prev_pending && bus.imem_req) chk("wait.addr_stable", bus.imem_addr, prev_addr);
            if (bus.inst_valid) begin
                chk("wait.pc", bus.inst_pc, exp_pc);
                chk("wait.inst", bus.inst, 32'hC000_0000 | exp_pc);
                exp_pc += 4;
                rcv++;
            end
        end
        chk("wait.received", rcv, 20);

        // aligned redirect on the same cycle as an ack
        bus.imem_ack = 1'b1;
        bus.inst_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        chk("redir.pre_addr", bus.imem_addr, 9'h8);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        chk("redir.count", bus.fifo_count, 0);
        chk("redir.valid", bus.inst_valid, 0);
        chk("redir.addr", bus.imem_addr, 9'h40);
        chk("redir.req", bus.imem_req, 1);
        bus.inst_ready = 1'b1;
        tick();
        chk("redir.first_pc", bus.inst_pc, 32'h40);
        chk("redir.first_inst", bus.inst, 32'hC000_0040);
        tick();
        chk("redir.second_pc", bus.inst_pc, 32'h44);

        // misaligned redirect, then recovery
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h42;
        tick();
        bus.redirect = 1'b0;
        chk("fault.fault", bus.fault, 1);
        chk("fault.req", bus.imem_req, 0);
        chk("fault.valid", bus.inst_valid, 0);
        chk("fault.count", bus.fifo_count, 0);
        chk("fault.pc_kept", bus.imem_addr, 9'h48);
        tick();
        chk("fault.sticky", bus.fault, 1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect = 1'b0;
        chk("recover.fault", bus.fault, 0);
        chk("recover.req", bus.imem_req, 1);
        chk("recover.addr", bus.imem_addr, 9'h80);
        tick();
        chk("recover.pc", bus.inst_pc, 32'h80);

        // reset with entries queued and a transfer pending
        bus.inst_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) tick();
        bus.imem_ack = 1'b0;
        chk("midrst.count", bus.fifo_count, 3);
        chk("midrst.req", bus.imem_req, 1);
        rst_n = 1'b0;
        tick();
        chk_zero("midrst");
        rst_n = 1'b1;
        bus.imem_ack = 1'b1;
        bus.inst_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        bus.redirect = 1'b0;
        chk("boot.redirect_ignored", bus.imem_addr, 0);
        chk("boot.req", bus.imem_req, 1);
        tick();
        chk("midrst.refetch", bus.inst_pc, 0);

        // PC wrap at the top of the address space
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        chk("wrap.addr", bus.imem_addr, 9'h1FC);
        chk("wrap.count", bus.fifo_count, 0);
        tick();
        chk("wrap.pc", bus.inst_pc, 32'hFFFF_FFFC);
        chk("wrap.pc4", bus.inst_pc4, 0);
        chk("wrap.inst", bus.inst, 32'hC000_01FC);
        chk("wrap.next_addr", bus.imem_addr, 0);
        tick();
        chk("wrap.next_pc", bus.inst_pc, 0);
        chk("wrap.next_pc4", bus.inst_pc4, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
